uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKDIV, default 104, meaning clk cycles per UART bit (12 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port uart_rx  input  1  raw asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port rdata  output  8  byte at FIFO head.
REQ-006 SHALL have port rvalid  output  1  FIFO non-empty; rdata valid.
REQ-007 SHALL have port rready  input  1  consumer accepts head byte when rvalid=1.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port overflow  output  1  one-cycle pulse: completed byte dropped, FIFO full.

Function
REQ-010 SHALL pass uart_rx through a 2-flop synchronizer (both flops reset to 1); all decisions use the second flop output (rxs).
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK with one bit-timer (width ceil(log2(CLKDIV))) and a 3-bit bit index.
REQ-012 IDLE: on rxs=0, load timer, go START; otherwise stay.
REQ-013 START: after CLKDIV/2 (integer divide) cycles sample rxs; 0 -> load timer with CLKDIV, index=0, go DATA; 1 -> glitch, return IDLE, no output.
REQ-014 DATA: every CLKDIV cycles sample rxs into shift register bit[index], LSB first; after index 7 sampled go STOP.
REQ-015 STOP: after CLKDIV cycles sample rxs; 1 -> push byte, go IDLE; 0 -> assert frame_err one cycle, discard byte, go BREAK.
REQ-016 BREAK: stay until rxs=1, then IDLE; no bytes or pulses generated while in BREAK.
REQ-017 Sample points SHALL be at mid-bit: data bit n sampled CLKDIV/2 + (n+1)*CLKDIV cycles after the IDLE-detected falling edge.
REQ-018 FIFO SHALL hold 4 bytes (2-bit pointers, 3-bit count), first-in first-out.
REQ-019 Push SHALL make the byte visible on rdata/rvalid the cycle after the stop-bit sample cycle (1-cycle latency).
REQ-020 Pop SHALL occur on any cycle with rvalid=1 and rready=1; rready with rvalid=0 SHALL have no effect.
REQ-021 rdata SHALL remain stable while rvalid=1 and no pop occurs.
REQ-022 Push when count=4 and no pop same cycle: byte dropped, overflow pulses one cycle, FIFO contents unchanged.
REQ-023 Push and pop same cycle: both SHALL take effect, count unchanged, including when full (no overflow).
REQ-024 Push and pop same cycle when empty is impossible (rvalid=0); push alone applies.
REQ-025 Pointers SHALL wrap modulo 4 without loss of ordering.
REQ-026 frame_err and overflow SHALL never assert in the same cycle; both are registered outputs.

Reset
REQ-027 While reset=1 SHALL hold: FSM=IDLE, sync flops=1, timer/index/shift=0, FIFO empty, rvalid=0, rdata=0, frame_err=0, overflow=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately; after release, the receiver SHALL not emit the partial byte and resumes in IDLE.
REQ-029 Deassertion SHALL be synchronized externally; block makes no guarantee for deassertion coincident with a uart_rx falling edge.

Verification (CLKDIV=8 unless stated)
REQ-030 Send 0xA5 8N1, rready=1 -> rvalid high for exactly 1 cycle with rdata=0xA5, starting 1 cycle after stop sample; no error pulses.
REQ-031 Low glitch of 3 cycles on idle line -> START rejects, no rvalid, no frame_err, FSM back to IDLE.
REQ-032 Send 0x3C with stop bit forced low, then hold line low 40 cycles -> exactly one frame_err pulse, no push; next frame 0x81 received as 0x81.
REQ-033 rready=0, send 0x01..0x05 -> FIFO holds 0x01..0x04, one overflow pulse on 5th; then drain -> 0x01,0x02,0x03,0x04 in order, rvalid drops.
REQ-034 FIFO full, rready pulsed exactly on the push cycle of a 5th byte 0x55 -> no overflow; drain yields 0x02,0x03,0x04,0x55.
REQ-035 Assert reset during DATA bit 4 of 0xFF, release, send 0x12 -> only 0x12 delivered; all outputs 0 during reset; repeat REQ-030 with CLKDIV=104.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a 4-entry byte FIFO.
//
// The raw serial line is brought into the clock domain through a two-flop
// synchronizer. A bit-timer FSM samples each bit at its midpoint and pushes
// completed bytes into a small FIFO that the consumer drains with a
// valid/ready handshake.
//
// Ports:
//   clk        sole clock, all state on the rising edge
//   reset      asynchronous, active-high reset
//   uart_rx    raw serial input, idle high, 8N1, LSB first
//   rdata      byte at the FIFO head (0 while the FIFO is empty)
//   rvalid     FIFO non-empty, rdata valid
//   rready     consumer accepts the head byte when rvalid is high
//   frame_err  one-cycle pulse: stop bit sampled low, byte discarded
//   overflow   one-cycle pulse: completed byte dropped because FIFO was full
//
// Parameter:
//   CLKDIV     clk cycles per UART bit, legal range 4..65535

module uart_rx_fifo #(
  parameter int CLKDIV = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rdata,
  output logic       rvalid,
  input  logic       rready,
  output logic       frame_err,
  output logic       overflow
);

  localparam int TW = $clog2(CLKDIV);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKDIV / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKDIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Synchronizer
  logic rx_meta_q;
  logic rxs_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // Receiver FSM
  state_t          state_q;
  logic [TW-1:0]   timer_q;
  logic [2:0]      idx_q;
  logic [7:0]      shift_q;

  // The timer counts down to zero; the sample is taken on the cycle it reads
  // zero, so loading N-1 places the sample N cycles after the load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            timer_q <= HALF_M1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (timer_q == '0) begin
            if (!rxs_q) begin
              timer_q <= FULL_M1;
              idx_q   <= 3'd0;
              state_q <= S_DATA;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state_q <= S_IDLE;
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_DATA: begin
          if (timer_q == '0) begin
            shift_q[idx_q] <= rxs_q;
            timer_q        <= FULL_M1;
            if (idx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_STOP: begin
          if (timer_q == '0) begin
            state_q <= rxs_q ? S_IDLE : S_BREAK;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_BREAK: begin
          // Wait out a held-low line so it is not mistaken for new start bits.
          if (rxs_q) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic stop_smp;
  logic push;
  logic ferr;

  assign stop_smp = (state_q == S_STOP) && (timer_q == '0);
  assign push     = stop_smp && rxs_q;
  assign ferr     = stop_smp && !rxs_q;

  // FIFO
  logic [7:0] mem_q [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       full;
  logic       pop;
  logic       do_push;
  logic       frame_err_q;
  logic       overflow_q;

  assign rvalid  = (count_q != 3'd0);
  assign full    = (count_q == 3'd4);
  assign pop     = rvalid && rready;
  // A pop in the same cycle frees the head slot, so a full FIFO still
  // accepts the push; the write lands in the slot being vacated.
  assign do_push = push && (!full || pop);
  assign rdata   = rvalid ? mem_q[rd_ptr_q] : 8'h00;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 2'd1;
    if (pop)     rd_ptr_d = rd_ptr_q + 2'd1;
    case ({do_push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      count_q     <= 3'd0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_err_q <= ferr;
      overflow_q  <= push && full && !pop;
    end
  end

  // Storage is only observable through rdata, which is gated by rvalid, so
  // it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_rx = 1'b1;
  logic       rready = 1'b0;
  logic [7:0] rdata;
  logic       rvalid;
  logic       frame_err;
  logic       overflow;

  logic       uart_rx104 = 1'b1;
  logic       rready104 = 1'b1;
  logic [7:0] rdata104;
  logic       rvalid104;
  logic       frame_err104;
  logic       overflow104;

  uart_rx_fifo #(.CLKDIV(8)) dut (
    .clk(clk), .reset(reset), .uart_rx(uart_rx), .rdata(rdata),
    .rvalid(rvalid), .rready(rready), .frame_err(frame_err), .overflow(overflow)
  );

  uart_rx_fifo #(.CLKDIV(104)) dut104 (
    .clk(clk), .reset(reset), .uart_rx(uart_rx104), .rdata(rdata104),
    .rvalid(rvalid104), .rready(rready104), .frame_err(frame_err104),
    .overflow(overflow104)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    int         t;   // expected pop cycle, or -1 when timing is not checked
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int rv_cycles = 0;
  int ferr_cnt = 0;
  int ovf_cnt = 0;
  int exp_ferr = 0;
  int exp_ovf = 0;
  int last_es = 0;

  int rv104_cnt = 0;
  int rv104_cyc = 0;
  int ferr104_cnt = 0;
  int ovf104_cnt = 0;
  logic [7:0] rd104_last = 8'h00;

  bit rand_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every accepted head byte is compared with the oldest
  // expected byte.
  always @(negedge clk) begin
    if (rvalid && rready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pop got %02h want none", rdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (rdata !== mon_e.d) begin
          errors++;
          $display("FAIL pop_data got %02h want %02h", rdata, mon_e.d);
        end
        if (mon_e.t >= 0) begin
          checks++;
          if (cyc != mon_e.t) begin
            errors++;
            $display("FAIL pop_time got %0d want %0d", cyc, mon_e.t);
          end
        end
      end
    end
    if (rvalid) rv_cycles++;
    if (frame_err) ferr_cnt++;
    if (overflow) ovf_cnt++;
    if (rvalid104) begin
      rv104_cnt++;
      rv104_cyc = cyc;
      rd104_last = rdata104;
    end
    if (frame_err104) ferr104_cnt++;
    if (overflow104) ovf104_cnt++;
  end

  // Reference model of FIFO acceptance: a byte fits if fewer than four are
  // waiting, or if the head leaves in the same cycle.
  function automatic bit model_accepts(input bit pop_same);
    return (exp_q.size() < 4) || pop_same;
  endfunction

  // mode: 0 = no byte expected, 1 = expected, 2 = expected with exact pop cycle
  // (rready must be high and the FIFO empty for the timed form).
  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input bit sel104, input int mode);
    int c;
    int es;
    logic [9:0] bits;
    exp_t e;
    c = sel104 ? 104 : 8;
    bits = {stop_ok, b, 1'b0};
    @(posedge clk); #1;
    // Two synchronizer flops plus one cycle for the idle check, then half a
    // bit to mid start, then nine full bits to mid stop.
    es = cyc + 3 + c / 2 + 9 * c;
    last_es = es;
    if (!sel104 && mode != 0) begin
      e.d = b;
      e.t = (mode == 2) ? es : -1;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      if (sel104) uart_rx104 = bits[i];
      else        uart_rx    = bits[i];
      repeat (c) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0;
    int ovf0;
    logic [7:0] b;
    bit bad;
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overflow", overflow, 0);
    @(posedge clk); #1 reset = 1'b0;
    idle(5);

    // Single byte, immediate consumer
    rready = 1'b1;
    r0 = rv_cycles;
    send_frame(8'hA5, 1'b1, 1'b0, 2);
    idle(10);
    check("a5_rvalid_cycles", rv_cycles - r0, 1);
    check("a5_frame_err", ferr_cnt, exp_ferr);
    check("a5_overflow", ovf_cnt, exp_ovf);

    // Short low glitch on the idle line
    r0 = rv_cycles;
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 uart_rx = 1'b1;
    idle(24);
    check("glitch_rvalid_cycles", rv_cycles - r0, 0);
    check("glitch_frame_err", ferr_cnt, exp_ferr);
    send_frame(8'h5A, 1'b1, 1'b0, 2);
    idle(10);

    // Bad stop bit with the line held low afterwards
    r0 = rv_cycles;
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    exp_ferr++;
    idle(32);
    uart_rx = 1'b1;
    idle(10);
    check("break_frame_err", ferr_cnt, exp_ferr);
    check("break_rvalid_cycles", rv_cycles - r0, 0);
    send_frame(8'h81, 1'b1, 1'b0, 2);
    idle(10);

    // Overflow with a stalled consumer
    rready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      if (model_accepts(1'b0)) begin
        send_frame(8'(v), 1'b1, 1'b0, 1);
      end else begin
        send_frame(8'(v), 1'b1, 1'b0, 0);
        exp_ovf++;
      end
      idle(2);
    end
    idle(4);
    check("full_overflow", ovf_cnt, exp_ovf);
    check("full_rvalid", rvalid, 1);
    check("full_head_stable", rdata, 8'h01);
    rready = 1'b1;
    wait_drain("full_drain", 50);
    idle(2);
    check("drained_rvalid", rvalid, 0);

    // Push while full with a pop on exactly the same cycle
    rready = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      send_frame(8'(v), 1'b1, 1'b0, 1);
      idle(2);
    end
    idle(4);
    ovf0 = ovf_cnt;
    fork
      send_frame(8'h55, 1'b1, 1'b0, model_accepts(1'b1) ? 1 : 0);
      begin
        @(posedge clk); #1;
        repeat (2 + 4 + 72) @(posedge clk);
        #1 rready = 1'b1;
        @(posedge clk);
        #1 rready = 1'b0;
      end
    join
    idle(4);
    check("same_cycle_overflow", ovf_cnt - ovf0, 0);
    rready = 1'b1;
    wait_drain("same_cycle_drain", 50);
    idle(2);

    // Randomized traffic with a randomly stalling consumer
    rand_on = 1'b1;
    fork
      begin
        for (int f = 0; f < 24; f++) begin
          n = 0;
          while (exp_q.size() >= 4 && n < 2000) begin
            @(posedge clk); #1;
            n++;
          end
          check("rand_space_wait", exp_q.size() < 4, 1);
          b = 8'($urandom);
          bad = ($urandom_range(0, 5) == 0);
          if (bad) begin
            send_frame(b, 1'b0, 1'b0, 0);
            exp_ferr++;
            idle($urandom_range(0, 20));
          end else begin
            send_frame(b, 1'b1, 1'b0, 1);
          end
          uart_rx = 1'b1;
          idle($urandom_range(1, 12));
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          rready = ($urandom_range(0, 1) == 1);
          @(posedge clk); #1;
        end
      end
    join
    rready = 1'b1;
    wait_drain("rand_drain", 200);
    idle(2);
    check("rand_frame_err", ferr_cnt, exp_ferr);
    check("rand_overflow", ovf_cnt, exp_ovf);

    // Reset in the middle of a frame, with a byte already buffered
    rready = 1'b0;
    send_frame(8'h33, 1'b1, 1'b0, 1);
    idle(4);
    check("pre_reset_rvalid", rvalid, exp_q.size() != 0);
    fork
      send_frame(8'hFF, 1'b1, 1'b0, 0);
      begin
        @(posedge clk); #1;
        repeat (1 + 4 + 5 * 8) @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("midrst_rvalid", rvalid, 0);
        check("midrst_rdata", rdata, 0);
        check("midrst_frame_err", frame_err, 0);
        check("midrst_overflow", overflow, 0);
        @(posedge clk); #1 reset = 1'b0;
      end
    join
    rready = 1'b1;
    r0 = rv_cycles;
    idle(20);
    check("post_reset_no_partial", rv_cycles - r0, 0);
    send_frame(8'h12, 1'b1, 1'b0, 2);
    idle(10);
    check("post_reset_rvalid_cycles", rv_cycles - r0, 1);

    // Default bit period on the second instance
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    idle(20);
    check("div104_rvalid_cycles", rv104_cnt, 1);
    check("div104_rdata", rd104_last, 8'hA5);
    check("div104_time", rv104_cyc, last_es);
    check("div104_frame_err", ferr104_cnt, 0);
    check("div104_overflow", ovf104_cnt, 0);

    check("final_queue_empty", exp_q.size(), 0);
    check("final_frame_err", ferr_cnt, exp_ferr);
    check("final_overflow", ovf_cnt, exp_ovf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
